// File: rtl/bcd_accumulator.sv
// Serial BCD-to-binary operand converter feeding a saturating/wrapping binary accumulator.
// One transaction: latch in IDLE, NUM_DIGITS CONVERT cycles (MSD first), one APPLY cycle.
module bcd_accumulator #(
  parameter int NUM_DIGITS = 3,
  parameter int ACC_WIDTH  = 10,
  parameter int SATURATE   = 1
) (
  input  logic                    clk,
  input  logic                    n_reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [1:0]              op,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic                    clr_flags,
  output logic [ACC_WIDTH-1:0]    acc_out,
  output logic                    done,
  output logic                    overflow,
  output logic                    underflow,
  output logic                    invalid_digit
);
  localparam int CW = 4*NUM_DIGITS;
  localparam int AW = ((CW > ACC_WIDTH) ? CW : ACC_WIDTH) + 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [AW-1:0] MAX_X = AW'({ACC_WIDTH{1'b1}});

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_SET = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  typedef enum logic [1:0] {IDLE, CONVERT, APPLY} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   digits_r, conv, conv_nxt;
  logic [1:0]      op_r;
  logic [IW-1:0]   idx;
  logic            bad;
  logic [3:0]      dig;
  logic [AW-1:0]   acc_x, conv_x, sum;
  logic [ACC_WIDTH-1:0] diff, res;
  logic            set_ovf, set_unf, set_inv, apply;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_valid) state_nxt = CONVERT;
      CONVERT: if (idx == '0)  state_nxt = APPLY;
      APPLY:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign load_ready = (state == IDLE);
  assign apply      = (state == APPLY);

  // value*10 as (value<<3)+(value<<1), avoiding a multiplier
  assign dig      = digits_r[4*idx +: 4];
  assign conv_nxt = {conv[CW-4:0], 3'b000} + {conv[CW-2:0], 1'b0} + CW'(dig);

  assign acc_x  = AW'(acc_out);
  assign conv_x = AW'(conv);
  assign sum    = acc_x + conv_x;
  assign diff   = acc_out - conv_x[ACC_WIDTH-1:0];

  always_comb begin
    res     = acc_out;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    set_inv = 1'b0;
    if (op_r != OP_CLR && bad) begin
      set_inv = 1'b1;
    end else begin
      case (op_r)
        OP_ADD: begin
          res = sum[ACC_WIDTH-1:0];
          if (sum > MAX_X) begin
            set_ovf = 1'b1;
            if (SATURATE != 0) res = {ACC_WIDTH{1'b1}};
          end
        end
        OP_SUB: begin
          res = diff;
          if (conv_x > acc_x) begin
            set_unf = 1'b1;
            if (SATURATE != 0) res = '0;
          end
        end
        OP_SET: begin
          res = conv_x[ACC_WIDTH-1:0];
          if (conv_x > MAX_X) begin
            set_ovf = 1'b1;
            if (SATURATE != 0) res = {ACC_WIDTH{1'b1}};
          end
        end
        default: res = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      digits_r      <= '0;
      op_r          <= '0;
      conv          <= '0;
      idx           <= '0;
      bad           <= 1'b0;
      acc_out       <= '0;
      done          <= 1'b0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
      invalid_digit <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (load_valid) begin
          digits_r <= digits_in;
          op_r     <= op;
          conv     <= '0;
          idx      <= IW'(NUM_DIGITS-1);
          bad      <= 1'b0;
        end
        CONVERT: begin
          conv <= conv_nxt;
          idx  <= idx - 1'b1;
          if (dig > 4'd9) bad <= 1'b1;
        end
        APPLY: begin
          acc_out <= res;
          done    <= 1'b1;
        end
        default: ;
      endcase
      // a flag set on the same edge as clr_flags wins
      overflow      <= (apply & set_ovf) | (overflow      & ~clr_flags);
      underflow     <= (apply & set_unf) | (underflow     & ~clr_flags);
      invalid_digit <= (apply & set_inv) | (invalid_digit & ~clr_flags);
    end
  end
endmodule

// File: tb/tb_bcd_accumulator.sv
// Scoreboard bench: saturating and wrapping instances share stimulus; an integer model
// predicts each retirement and a monitor compares on every done pulse.
module tb_bcd_accumulator;
  localparam int ND  = 3;
  localparam int AWD = 10;
  localparam int MAX = 1023;

  logic            clk = 1'b0;
  logic            n_reset = 1'b0;
  logic [4*ND-1:0] digits_in = '0;
  logic [1:0]      op = '0;
  logic            load_valid = 1'b0;
  logic            clr_flags = 1'b0;
  logic            ready_s, ready_w, done_s, done_w;
  logic [AWD-1:0]  acc_s, acc_w;
  logic            ovf_s, unf_s, inv_s, ovf_w, unf_w, inv_w;

  bcd_accumulator #(.NUM_DIGITS(ND), .ACC_WIDTH(AWD), .SATURATE(1)) u_sat (
    .clk(clk), .n_reset(n_reset), .digits_in(digits_in), .op(op), .load_valid(load_valid),
    .load_ready(ready_s), .clr_flags(clr_flags), .acc_out(acc_s), .done(done_s),
    .overflow(ovf_s), .underflow(unf_s), .invalid_digit(inv_s));

  bcd_accumulator #(.NUM_DIGITS(ND), .ACC_WIDTH(AWD), .SATURATE(0)) u_wrap (
    .clk(clk), .n_reset(n_reset), .digits_in(digits_in), .op(op), .load_valid(load_valid),
    .load_ready(ready_w), .clr_flags(clr_flags), .acc_out(acc_w), .done(done_w),
    .overflow(ovf_w), .underflow(unf_w), .invalid_digit(inv_w));

  always #5 clk = ~clk;

  typedef struct {
    int acc_s, acc_w;
    bit ovf_s, unf_s, inv_s, ovf_w, unf_w, inv_w;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_acc[2];
  bit   m_ovf[2], m_unf[2], m_inv[2];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic logic [4*ND-1:0] dec(input int v);
    logic [4*ND-1:0] r;
    r = '0;
    for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'((v / (10**i)) % 10);
    return r;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_acc[m] = 0; m_ovf[m] = 0; m_unf[m] = 0; m_inv[m] = 0;
    end
  endtask

  task automatic model_clr();
    for (int m = 0; m < 2; m++) begin
      m_ovf[m] = 0; m_unf[m] = 0; m_inv[m] = 0;
    end
  endtask

  // mode 0 saturates, mode 1 wraps modulo 2**AWD
  task automatic model_txn(input int o, input logic [4*ND-1:0] dg);
    int opd, r, d;
    bit bad;
    exp_t e;
    opd = 0; bad = 0;
    for (int i = 0; i < ND; i++) begin
      d = int'(dg[4*i +: 4]);
      if (d > 9) bad = 1;
      opd += d * (10**i);
    end
    for (int m = 0; m < 2; m++) begin
      r = m_acc[m];
      if (o != 3 && bad) m_inv[m] = 1;
      else case (o)
        0: begin
          r = m_acc[m] + opd;
          if (r > MAX) begin m_ovf[m] = 1; r = (m == 0) ? MAX : r % (MAX+1); end
        end
        1: begin
          if (opd > m_acc[m]) begin
            m_unf[m] = 1;
            r = (m == 0) ? 0 : ((m_acc[m] - opd) % (MAX+1) + (MAX+1)) % (MAX+1);
          end else r = m_acc[m] - opd;
        end
        2: begin
          r = opd;
          if (r > MAX) begin m_ovf[m] = 1; r = (m == 0) ? MAX : r % (MAX+1); end
        end
        default: r = 0;
      endcase
      m_acc[m] = r;
    end
    e.acc_s = m_acc[0]; e.ovf_s = m_ovf[0]; e.unf_s = m_unf[0]; e.inv_s = m_inv[0];
    e.acc_w = m_acc[1]; e.ovf_w = m_ovf[1]; e.unf_w = m_unf[1]; e.inv_w = m_inv[1];
    q.push_back(e);
  endtask

  task automatic wait_ready();
    int k = 0;
    @(negedge clk);
    while (!ready_s && k < 50) begin @(negedge clk); k++; end
    chk("ready_timeout", int'(ready_s), 1);
  endtask

  // returns 1 ns after the handshake edge; digits/op scrambled to prove they are ignored
  task automatic issue(input int o, input logic [4*ND-1:0] dg);
    wait_ready();
    load_valid = 1'b1; op = 2'(o); digits_in = dg;
    model_txn(o, dg);
    @(posedge clk); #1;
    load_valid = 1'b0; op = 2'($urandom); digits_in = 12'($urandom);
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done_s && k < 50) begin @(negedge clk); k++; end
    chk("done_timeout", int'(done_s), 1);
  endtask

  task automatic pulse_clr();
    wait_ready();
    clr_flags = 1'b1;
    model_clr();
    @(negedge clk);
    clr_flags = 1'b0;
    chk("clr_flags_s", int'({ovf_s, unf_s, inv_s}), 0);
    chk("clr_flags_w", int'({ovf_w, unf_w, inv_w}), 0);
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (done_s || done_w) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          e = q.pop_front();
          chk("done_pair", int'(done_w), int'(done_s));
          chk("acc_sat", int'(acc_s), e.acc_s);
          chk("acc_wrap", int'(acc_w), e.acc_w);
          chk("ovf_sat", int'(ovf_s), int'(e.ovf_s));
          chk("unf_sat", int'(unf_s), int'(e.unf_s));
          chk("inv_sat", int'(inv_s), int'(e.inv_s));
          chk("ovf_wrap", int'(ovf_w), int'(e.ovf_w));
          chk("unf_wrap", int'(unf_w), int'(e.unf_w));
          chk("inv_wrap", int'(inv_w), int'(e.inv_w));
        end
      end
    end
  end

  initial begin
    int lowcnt, seen, o, v;
    logic [4*ND-1:0] dg;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_acc", int'(acc_s) + int'(acc_w), 0);
    chk("rst_done_flags", int'({done_s, ovf_s, unf_s, inv_s, done_w, ovf_w, unf_w, inv_w}), 0);
    chk("rst_ready", int'(ready_s & ready_w), 1);
    n_reset = 1'b1;

    // latency: ready low for ND+1 cycles, done with ready on retirement
    issue(0, 12'h123);
    lowcnt = 0;
    while (lowcnt < 20) begin
      @(negedge clk);
      if (ready_s) break;
      lowcnt++;
    end
    chk("ready_low_cycles", lowcnt, ND+1);
    chk("done_with_ready", int'(done_s), 1);

    issue(3, 12'h000);
    issue(0, 12'h999);
    issue(0, 12'h999);
    pulse_clr();
    issue(2, 12'h005);
    issue(1, 12'h007);
    pulse_clr();
    issue(2, 12'h005);
    issue(1, 12'h003);
    issue(0, 12'h1A0);
    pulse_clr();
    issue(3, 12'hFFF);

    // clr_flags held across an overflowing retirement: the set must win
    issue(2, 12'h999);
    wait_ready();
    clr_flags = 1'b1;
    model_clr();
    issue(0, 12'h999);
    @(negedge clk);
    wait_done();
    clr_flags = 1'b0;

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(9) == 0) pulse_clr();
      o  = int'($urandom_range(3));
      v  = int'($urandom_range(999));
      dg = dec(v);
      if ($urandom_range(7) == 0) dg[4*$urandom_range(ND-1) +: 4] = 4'($urandom_range(15, 10));
      issue(o, dg);
    end

    // reset during the second CONVERT cycle aborts the transaction
    issue(2, 12'h500);
    issue(0, 12'h123);
    @(posedge clk); #2;
    n_reset = 1'b0;
    #1;
    q.delete();
    model_reset();
    chk("midrst_acc", int'(acc_s) + int'(acc_w), 0);
    chk("midrst_outs", int'({done_s, ovf_s, unf_s, inv_s, done_w, ovf_w, unf_w, inv_w}), 0);
    chk("midrst_ready", int'(ready_s & ready_w), 1);
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done_s || done_w) seen = 1;
    end
    chk("no_done_after_rst", seen, 0);
    chk("ready_after_rst", int'(ready_s), 1);
    issue(0, 12'h005);

    begin
      int k = 0;
      while (q.size() != 0 && k < 50) begin @(negedge clk); k++; end
      chk("drain", q.size(), 0);
    end
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
